// File: rtl/accum_pkg.sv
// Shared types and sizes for the frame accumulator.
// Contents: accumulator FSM state type and default widths (ACC_W, ACC_CW).
// No ports; imported by accum_stage32.
package accum_pkg;

  localparam int ACC_W  = 32;
  localparam int ACC_CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } accum_state_t;

endpackage

// File: rtl/prefix_adder_w.sv
// Combinational W-bit Brent-Kung prefix adder (carry-in fixed at 0).
// Ports: a, b (W-bit operands) -> sum (W-bit), cout (carry out of the MSB).
// Zero latency; no flow control.
module prefix_adder_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IW  = (W > 1) ? $clog2(W) : 1;
  // Largest span used by the down-sweep; spans beyond W simply find no nodes.
  localparam int TOP = (W > 1) ? (1 << (IW - 1)) : 1;

  logic [W-1:0] p;
  logic [W-1:0] gp;
  logic [W-1:0] pp;

  assign p = a ^ b;

  always_comb begin
    gp = a & b;
    pp = p;
    // Up-sweep: build group (g,p) over power-of-two spans at odd tree nodes.
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
        gp[IW'(i)] = gp[IW'(i)] | (pp[IW'(i)] & gp[IW'(i - d)]);
        pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - d)];
      end
    end
    // Down-sweep: fill in the remaining prefixes from completed neighbours.
    for (int d = TOP; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
        gp[IW'(i)] = gp[IW'(i)] | (pp[IW'(i)] & gp[IW'(i - d)]);
        pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - d)];
      end
    end
  end

  // gp[i] is now the carry into bit i+1.
  assign sum  = p ^ {gp[W-2:0], 1'b0};
  assign cout = gp[W-1];

endmodule

// File: rtl/accum_stage32.sv
// Frame accumulator: sums a valid/ready operand stream per frame and presents one
// result per frame (sum, carry-out count, overflow flag) on a valid/ready output.
// Ports: clk/rst, in_valid/in_ready/in_data/in_first/in_last, out_valid/out_ready/out_sum/out_carry_cnt/out_ovf.
// Optional: define ACCUM_STAGE32_SAT_EN to saturate the sum to all-ones on carry-out (default: wrap).
module accum_stage32
  import accum_pkg::*;
#(
  parameter int W  = ACC_W,
  parameter int CW = ACC_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_first,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_carry_cnt,
  output logic          out_ovf
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  accum_state_t  state;
  accum_state_t  state_nxt;
  logic [W-1:0]  acc;
  logic [CW-1:0] carry_cnt;
  logic          ovf;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          accept;
  logic          load;
  logic          add;

  prefix_adder_w #(.W(W)) u_adder (
    .a    (acc),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // In HOLD the result drains and a new beat loads in the same cycle.
  assign in_ready = (state == HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid & in_ready;
  // A first beat inside ACC restarts the frame, discarding the partial sum.
  assign load     = accept & ((state != ACC) | in_first);
  assign add      = accept & (state == ACC) & ~in_first;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = in_last ? HOLD : ACC;
    end else if ((state == HOLD) && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      carry_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        acc       <= in_data;
        carry_cnt <= '0;
        ovf       <= 1'b0;
      end else if (add) begin
`ifdef ACCUM_STAGE32_SAT_EN
        // Once saturated, any further non-zero beat carries again, so the sum stays all-ones.
        acc <= add_cout ? {W{1'b1}} : add_sum;
`else
        acc <= add_sum;
`endif
        if (add_cout) begin
          ovf <= 1'b1;
          if (carry_cnt != CNT_MAX) begin
            carry_cnt <= carry_cnt + CNT_ONE;
          end
        end
      end
    end
  end

  // Result registers double as the running state; they are only meaningful while out_valid.
  assign out_valid     = (state == HOLD);
  assign out_sum       = acc;
  assign out_carry_cnt = carry_cnt;
  assign out_ovf       = ovf;

endmodule
